fifo_rd_stage: RTL and testbench
================================

FIFO_RD_STAGE -- requirements
Module: fifo_rd_stage

Interface
REQ-001 Parameter: FIFO_WIDTH, 16, width of FIFO read data and output data.
REQ-002 Parameter: BUF_DEPTH, 2, output buffer entries; fixed at 2.
REQ-003 clk  input  1  single clock; all logic samples on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  when 1, block may issue FIFO reads.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid one cycle after an accepted read.
REQ-008 fifo_underflow  input  1  FIFO underflow flag, aligned with fifo_data_out.
REQ-009 fifo_rd_en  output  1  read request to the FIFO.
REQ-010 m_data  output  FIFO_WIDTH  output word, the head of the buffer.
REQ-011 m_valid  output  1  m_data valid.
REQ-012 m_ready  input  1  consumer accepts m_data.
REQ-013 rd_count  output  16  count of words transferred on the m_* handshake.
REQ-014 underflow_err  output  1  sticky protocol-fault flag.

Function
REQ-015 The block shall keep a registered occupancy count occ (0..2) and a registered in-flight flag pend, where pend = 1 in the cycle after fifo_rd_en=1.
REQ-016 pop is defined as m_valid & m_ready; a transfer occurs on every cycle where pop = 1.
REQ-017 fifo_rd_en shall be computed combinationally as enable & !fifo_empty & ((occ + pend - pop) < 2).
- This path from m_ready to fifo_rd_en is intentional.
REQ-018 fifo_rd_en shall never be 1 while fifo_empty = 1.
REQ-019 In every cycle where pend = 1 and fifo_underflow = 0, the block shall write fifo_data_out into the buffer tail at that clock edge.
REQ-020 In a cycle where pend = 1 and fifo_underflow = 1, the block shall discard the data, leave occ unchanged by the capture, and set underflow_err.
REQ-021 occ_next = occ + capture - pop.
- A simultaneous capture and pop leaves occ unchanged.
- Capture into an empty buffer appears on m_data one cycle later.
REQ-022 Ordering shall be strict FIFO: words leave on m_data in the order they were read.
REQ-023 m_valid shall equal (occ != 0), and m_data shall equal the head entry.
- m_data shall hold stable while m_valid = 1 and m_ready = 0.
REQ-024 With enable = 1, FIFO never empty, and m_ready held at 1, the block shall sustain one transfer per cycle after an initial latency of 2 cycles from the first fifo_rd_en to the first m_valid.
REQ-025 With m_ready = 0, the block shall stop issuing reads once occ + pend = 2, and shall never overflow the buffer.
REQ-026 Deasserting enable shall stop new reads only.
- An in-flight word shall still be captured.
- Buffered words shall still drain on m_ready.
REQ-027 rd_count shall increment by 1 on each pop and wrap from 16'hFFFF to 0.
REQ-028 underflow_err, once set, shall remain 1 until rst.

Reset
REQ-029 When rst = 1 at a clock edge, the block shall set occ = 0, pend = 0, m_valid = 0, m_data = 0, rd_count = 0 and underflow_err = 0.
REQ-030 While rst = 1, fifo_rd_en shall be 0.
REQ-031 A word in flight when rst is asserted shall be discarded and shall not appear on m_data after reset.
REQ-032 The first fifo_rd_en after reset shall occur no earlier than the first cycle with rst = 0.

Verification
REQ-033 Streaming: FIFO preloaded with 0x0001..0x0008, enable = 1, m_ready = 1 -> m_data delivers 0x0001..0x0008 on 8 consecutive cycles; rd_count = 8; fifo_rd_en never asserted while fifo_empty = 1.
REQ-034 Backpressure: FIFO holds 0xA000..0xA004, m_ready = 0 for 10 cycles -> exactly 2 reads issued, m_data = 0xA000 stable; after m_ready = 1, the order 0xA000..0xA004 is preserved with no loss or duplicate.
REQ-035 Simultaneous capture and pop at occ = 1 -> occ stays 1 and m_data advances to the next word with no bubble.
REQ-036 Reset mid-flight: assert rst in the cycle after fifo_rd_en = 1 -> m_valid = 0, rd_count = 0, and the in-flight word never appears on m_data.
REQ-037 Fault injection: force fifo_underflow = 1 during a capture cycle -> word dropped, underflow_err = 1 and held until rst.
REQ-038 Counter wrap: 65537 transfers -> rd_count = 1.

Source files
------------

// File: rtl/fifo_rd_stage.sv
// Prefetching read stage: pulls words from a 1-cycle-latency FIFO into a 2-entry buffer for an m_* valid/ready port.
// Latency 2 cycles from fifo_rd_en to m_valid; reads stop once buffered plus in-flight words would exceed the buffer.
module fifo_rd_stage #(
    parameter int FIFO_WIDTH = 16,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [15:0]           rd_count,
    output logic                  underflow_err
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int OW = $clog2(BUF_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] entry [BUF_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [OW-1:0]         occ;
    logic                  pend;
    logic                  pop;
    logic                  capture;
    logic [OW:0]           occ_fut;

    assign pop     = m_valid & m_ready;
    assign capture = pend & ~fifo_underflow;

    // Occupancy the buffer will have once the in-flight word lands and this cycle's pop leaves.
    assign occ_fut    = {1'b0, occ} + {{OW{1'b0}}, pend} - {{OW{1'b0}}, pop};
    assign fifo_rd_en = ~rst & enable & ~fifo_empty & (occ_fut < (OW+1)'(BUF_DEPTH));

    assign m_valid = (occ != '0);
    assign m_data  = entry[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            occ           <= '0;
            pend          <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            rd_count      <= 16'd0;
            underflow_err <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            pend <= fifo_rd_en;
            if (capture) begin
                entry[wr_ptr] <= fifo_data_out;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                rd_count <= rd_count + 16'd1;
            end
            occ <= occ + {{(OW-1){1'b0}}, capture} - {{(OW-1){1'b0}}, pop};
            // A flagged underflow drops the returned word but is remembered until reset.
            if (pend && fifo_underflow) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Randomized and directed bench for fifo_rd_stage: a queue-based FIFO source plus a scoreboard of expected words.
module tb_fifo_rd_stage;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] rd_count;
    logic        underflow_err;

    fifo_rd_stage #(.FIFO_WIDTH(16), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .rd_count       (rd_count),
        .underflow_err  (underflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [15:0] src_q [$];
    logic [15:0] exp_q [$];

    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  rd_issued = 0;
    int  pops = 0;
    int  first_rd = -1;
    int  first_vld = -1;
    int  first_pop = -1;
    int  last_pop = -1;
    bit  en_k = 0, rdy_k = 0, rst_k = 1;
    bit  last_rd = 0, inj_next = 0, inj_now = 0, mon_on = 0;
    bit  prev_stall = 0;
    logic [15:0] prev_data = '0;
    logic [15:0] mdl_cnt = '0;
    bit  mdl_err = 0;

    function automatic void chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // One clock cycle: the source FIFO returns the word for last cycle's read, then inputs are applied.
    task automatic step();
        logic [15:0] w;
        @(negedge clk);
        cyc++;
        rst     = rst_k;
        enable  = en_k;
        m_ready = rdy_k;
        if (rst_k) exp_q.delete();
        inj_now = 0;
        if (last_rd && src_q.size() > 0) begin
            w = src_q.pop_front();
            fifo_data_out = w;
            if (inj_next) begin
                fifo_underflow = 1'b1;
                inj_now  = !rst_k;
                inj_next = 0;
            end else begin
                fifo_underflow = 1'b0;
                if (!rst_k) exp_q.push_back(w);
            end
        end else begin
            fifo_underflow = 1'b0;
            fifo_data_out  = 16'($urandom);
        end
        fifo_empty = (src_q.size() == 0);
        #1;
        chk(!(fifo_rd_en && fifo_empty), "rd_en_while_empty", {31'd0, fifo_rd_en}, 0);
        if (rst) chk(fifo_rd_en == 1'b0, "rd_en_in_reset", {31'd0, fifo_rd_en}, 0);
        last_rd = fifo_rd_en;
        if (fifo_rd_en) begin
            rd_issued++;
            if (first_rd < 0) first_rd = cyc;
        end
    endtask

    task automatic do_reset();
        rst_k = 1; en_k = 0; rdy_k = 0;
        step();
        step();
        mon_on = 1;
        rst_k = 0;
        step();
        chk(m_valid == 1'b0, "reset_m_valid", {31'd0, m_valid}, 0);
        chk(m_data == 16'h0, "reset_m_data", {16'd0, m_data}, 0);
        chk(rd_count == 16'h0, "reset_rd_count", {16'd0, rd_count}, 0);
        chk(underflow_err == 1'b0, "reset_underflow_err", {31'd0, underflow_err}, 0);
    endtask

    task automatic clear_stats();
        rd_issued = 0; pops = 0;
        first_rd = -1; first_vld = -1; first_pop = -1; last_pop = -1;
    endtask

    // Monitor: compares every transfer against the scoreboard and tracks the count and sticky-error models.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_on) begin
                chk(rd_count == mdl_cnt, "rd_count", {16'd0, rd_count}, {16'd0, mdl_cnt});
                chk(underflow_err == mdl_err, "underflow_err", {31'd0, underflow_err}, {31'd0, mdl_err});
                if (!rst) begin
                    if (prev_stall)
                        chk(m_valid && m_data == prev_data, "hold_under_backpressure", {16'd0, m_data}, {16'd0, prev_data});
                    if (m_valid && first_vld < 0) first_vld = cyc;
                    if (m_valid && m_ready) begin
                        if (exp_q.size() == 0) chk(0, "unexpected_word", {16'd0, m_data}, 0);
                        else begin
                            logic [15:0] e;
                            e = exp_q.pop_front();
                            chk(m_data == e, "m_data_order", {16'd0, m_data}, {16'd0, e});
                        end
                        pops++;
                        if (first_pop < 0) first_pop = cyc;
                        last_pop = cyc;
                    end
                end
                prev_stall = !rst && m_valid && !m_ready;
                prev_data  = m_data;
                if (rst) begin
                    mdl_cnt = '0;
                    mdl_err = 0;
                end else begin
                    if (m_valid && m_ready) mdl_cnt = mdl_cnt + 16'd1;
                    if (inj_now) mdl_err = 1;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
        fifo_data_out = '0; fifo_underflow = 1'b0;

        // Streaming: eight words back to back.
        do_reset();
        for (int i = 1; i <= 8; i++) src_q.push_back(16'(i));
        clear_stats();
        en_k = 1; rdy_k = 1;
        repeat (14) step();
        chk(first_vld - first_rd == 2, "first_latency", 32'(first_vld - first_rd), 2);
        chk(pops == 8, "stream_pops", 32'(pops), 8);
        chk(last_pop - first_pop == 7, "stream_back_to_back", 32'(last_pop - first_pop), 7);
        chk(rd_count == 16'd8, "stream_rd_count", {16'd0, rd_count}, 8);

        // Backpressure: only two reads may be outstanding with m_ready low.
        do_reset();
        src_q.delete();
        for (int i = 0; i < 5; i++) src_q.push_back(16'hA000 + 16'(i));
        clear_stats();
        en_k = 1; rdy_k = 0;
        repeat (10) step();
        chk(rd_issued == 2, "bp_reads_issued", 32'(rd_issued), 2);
        chk(m_valid && m_data == 16'hA000, "bp_head", {16'd0, m_data}, 32'hA000);
        clear_stats();
        rdy_k = 1;
        repeat (10) step();
        chk(pops == 5, "bp_drain_pops", 32'(pops), 5);
        chk(exp_q.size() == 0, "bp_scoreboard_empty", 32'(exp_q.size()), 0);

        // Reset in the cycle after a read: that word must vanish.
        do_reset();
        src_q.delete();
        for (int i = 0; i < 4; i++) src_q.push_back(16'hB000 + 16'(i));
        clear_stats();
        en_k = 1; rdy_k = 0;
        step();
        chk(last_rd == 1, "midflight_read_issued", {31'd0, last_rd}, 1);
        rst_k = 1; en_k = 0;
        step();
        rst_k = 0;
        step();
        chk(m_valid == 1'b0, "midflight_m_valid", {31'd0, m_valid}, 0);
        chk(rd_count == 16'd0, "midflight_rd_count", {16'd0, rd_count}, 0);
        clear_stats();
        en_k = 1; rdy_k = 1;
        repeat (8) step();
        chk(pops == 3, "midflight_pops", 32'(pops), 3);

        // Underflow on the first capture: word dropped, error sticks until reset.
        do_reset();
        src_q.delete();
        for (int i = 0; i < 4; i++) src_q.push_back(16'hC000 + 16'(i));
        clear_stats();
        inj_next = 1;
        en_k = 1; rdy_k = 1;
        repeat (10) step();
        chk(pops == 3, "fault_pops", 32'(pops), 3);
        chk(underflow_err == 1'b1, "fault_err_set", {31'd0, underflow_err}, 1);
        en_k = 0;
        repeat (5) step();
        chk(underflow_err == 1'b1, "fault_err_sticky", {31'd0, underflow_err}, 1);
        do_reset();

        // Random traffic with occasional resets and underflow faults.
        src_q.delete();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) src_q.push_back(16'($urandom));
            en_k  = ($urandom_range(0, 3) != 0);
            rdy_k = ($urandom_range(0, 2) != 0);
            rst_k = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) inj_next = 1;
            step();
        end
        rst_k = 0; en_k = 1; rdy_k = 1; inj_next = 0;
        for (int i = 0; i < 2000 && (exp_q.size() > 0 || src_q.size() > 0 || last_rd); i++) step();
        step();
        chk(exp_q.size() == 0, "random_drained", 32'(exp_q.size()), 0);

        // Counter wrap: 65537 transfers.
        do_reset();
        src_q.delete();
        for (int i = 0; i < 65537; i++) src_q.push_back(16'(i));
        clear_stats();
        en_k = 1; rdy_k = 1;
        for (int i = 0; i < 66000 && pops < 65537; i++) step();
        chk(pops == 65537, "wrap_pops", 32'(pops), 65537);
        chk(rd_count == 16'd1, "wrap_rd_count", {16'd0, rd_count}, 1);

        en_k = 0;
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
